ps2_kbd_ctrl: RTL and testbench
===============================

Name: ps2_kbd_ctrl

Overview:
- Sequencer and scan-code assembler placed directly after ps2_rx.
- Drives ps2_rx.rx_en and consumes its rx_done_tick/dout byte stream.
- Decodes Set-2 prefix bytes (E0 extended, F0 break) into one key event per keystroke and buffers events in a small show-ahead FIFO for the host logic.
- Throttles the receiver when the FIFO is full.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; power of two, 2..16.
- TIMEOUT_CYC, 50000: clk cycles allowed between a prefix byte and the byte that completes it; 1 ms at 50 MHz.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_done_tick  in  1  one-cycle pulse from ps2_rx: byte complete.
- rx_dout  in  8  received byte; valid when rx_done_tick=1.
- rx_en  out  1  enable to ps2_rx.
- rd_en  in  1  host pops the head event.
- key_valid  out  1  FIFO not empty.
- key_code  out  8  head event scan code.
- key_break  out  1  head event is a release.
- key_ext  out  1  head event carried an E0 prefix.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- ovf_tick  out  1  one-cycle pulse: an event was dropped.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, FIFO empty, timeout counter=0.
- Output values while in reset: rx_en=0, key_valid=0, key_code=0, key_break=0, key_ext=0, fifo_full=0, ovf_tick=0.
- rx_en = registered ~fifo_full; it is 1 on the first clk edge after reset release with an empty FIFO.
- FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. It acts only on cycles with rx_done_tick=1.
- IDLE:
  - byte E0 -> GOT_E0.
  - byte F0 -> GOT_F0.
  - bytes AA, FA, FE, EE, 00, FF are discarded; state stays IDLE.
  - any other byte -> emit {code=byte, break=0, ext=0}; stay IDLE.
- GOT_E0:
  - byte F0 -> GOT_E0F0.
  - byte E0 -> stay GOT_E0.
  - any other byte -> emit {byte, 0, 1}; go to IDLE.
- GOT_F0: any byte other than E0/F0 -> emit {byte, 1, 0}; go to IDLE. E0 or F0 -> discard and go to IDLE (protocol error).
- GOT_E0F0: any byte other than E0/F0 -> emit {byte, 1, 1}; go to IDLE. E0 or F0 -> discard and go to IDLE.
- Timeout:
  - The counter clears on every rx_done_tick and counts only in the three prefix states.
  - At TIMEOUT_CYC-1 the FSM goes to IDLE with no event, and the counter clears.
  - If rx_done_tick arrives on the same cycle as the timeout, the byte wins: it is processed with the current state.
- Latency: the event is written to the FIFO on the edge after the cycle with rx_done_tick; key_valid/key_code update on that same edge.
- FIFO:
  - Show-ahead: the head is visible on key_* whenever key_valid=1.
  - rd_en with the FIFO empty is ignored.
  - Write and read in the same cycle: both happen and the count is unchanged, including when the FIFO is full.
  - Write with the FIFO full and no read: the event is dropped and ovf_tick=1 for one cycle.
  - key_* hold their last value when the FIFO is empty.
- Pointer arithmetic: log2(FIFO_DEPTH)-bit pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- Reset mid-sequence (any state, any FIFO fill) returns everything to the reset values immediately.

Optional Feature:
- Macro: PS2_KBD_TYPEMATIC_FILTER_EN.
- Defined:
  - A 9-bit last_make {ext, code} register with a valid flag is kept.
  - A make event equal to last_make while the flag is set is suppressed: no FIFO write, no ovf_tick.
  - A break event whose {ext, code} matches last_make clears the flag.
  - Any new, different make event replaces last_make.
  - Reset clears the flag.
- Not defined: every make event is queued, including auto-repeats; no extra registers are built.

Decomposition:
- Package ps2_kbd_pkg:
  - Constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0.
  - The discard-byte list.
  - The kbd_state_t enum (IDLE, GOT_E0, GOT_F0, GOT_E0F0).
  - Event typedef kbd_evt_t {ext, brk, code[7:0]}, 10 bits.
- Sub-module ps2_evt_fifo:
  - Parameterised depth, width = width of kbd_evt_t.
  - Ports: wr, din, rd, dout, empty, full, ovf.
- The FSM, timeout counter and optional filter stay in ps2_kbd_ctrl.

Test Plan:
- Reset release, byte 1C -> one cycle later key_valid=1, key_code=1C, key_break=0, key_ext=0; rd_en for 1 cycle -> key_valid=0.
- Bytes E0, F0, 75 -> exactly one event {75, break=1, ext=1}; no event for the prefix bytes.
- Byte F0, then TIMEOUT_CYC idle cycles, then 1C -> single event {1C, break=0, ext=0}; the pending break is discarded.
- FIFO_DEPTH+1 make codes 15, 1D, 24, 2D, 2C with no reads:
  - fifo_full=1 and rx_en=0 after the 4th event.
  - ovf_tick pulses once on the 5th.
  - Draining returns 15, 1D, 24, 2D in order.
- FIFO full with rd_en=1 on the same cycle a new event is written -> count stays 4, ovf_tick=0, the new event is last in order.
- Filter enabled: bytes 1C, 1C, 1C, F0, 1C, 1C -> events {1C, make}, {1C, break}, {1C, make}. Filter disabled: five events.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// rtl/ps2_kbd_pkg.sv - shared constants and types for the PS/2 keyboard controller
//
// Purpose: Set-2 prefix bytes, the list of bytes discarded in IDLE, the
//          sequencer state enum and the 10-bit key event record.
// Ports:   none (package).
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  // Keyboard replies (BAT ok, ACK, resend, echo, errors) that never form a key event
  localparam int PS2_DISCARD_N = 6;
  localparam logic [7:0] PS2_DISCARD [PS2_DISCARD_N] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } kbd_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  localparam int KBD_EVT_W = $bits(kbd_evt_t);

  function automatic logic ps2_is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_DISCARD_N; i++) begin
      if (b == PS2_DISCARD[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - show-ahead event FIFO with overflow pulse
//
// Purpose: small FIFO whose head is always presented on dout; dout holds its
//          last value once the FIFO drains.
// Ports:   clk, rst       - clock, async active-high reset
//          wr, din        - write strobe and data (dropped when full w/o read)
//          rd             - pop head (ignored when empty)
//          dout           - head entry
//          empty, full    - occupancy flags
//          ovf            - one-cycle pulse, registered, when a write was dropped
module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]      count, count_nxt;
  logic [WIDTH-1:0] head_q, head_nxt;
  logic             do_wr, do_rd, ovf_q;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A full FIFO still accepts a write when a read frees a slot the same cycle
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  assign rd_ptr_nxt = do_rd ? rd_ptr + 1'b1 : rd_ptr;
  assign count_nxt  = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);

  // The write can only land on the next head slot when that slot is empty,
  // so forward din instead of the stale memory word.
  assign head_nxt = (do_wr && (wr_ptr == rd_ptr_nxt)) ? din : mem[rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (count_nxt != '0) head_q <= head_nxt;
      ovf_q  <= wr & full & ~do_rd;
    end
  end

  assign dout = head_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 Set-2 scan-code assembler and event queue
//
// Purpose: folds E0/F0 prefixes into one key event per keystroke, queues
//          events for the host and throttles ps2_rx when the queue is full.
//          Optional macro PS2_KBD_TYPEMATIC_FILTER_EN suppresses auto-repeat
//          make events.
// Ports:   clk, reset              - clock, async active-high reset
//          rx_done_tick, rx_dout   - byte stream from ps2_rx
//          rx_en                   - receiver enable (registered ~fifo_full)
//          rd_en                   - host pops head event
//          key_valid, key_code,
//          key_break, key_ext      - head event (show-ahead)
//          fifo_full, ovf_tick     - queue full / event dropped pulse
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_dout,
  output logic       rx_en,
  input  logic       rd_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       fifo_full,
  output logic       ovf_tick
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  kbd_state_t      state, state_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            emit, fifo_wr, fifo_empty, fifo_full_w, rx_en_q;
  kbd_evt_t        evt, head;
  logic            is_pfx;

  assign is_pfx  = (rx_dout == PS2_PFX_EXT) || (rx_dout == PS2_PFX_BRK);
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    evt.ext   = 1'b0;
    evt.brk   = 1'b0;
    evt.code  = rx_dout;
    if (rx_done_tick) begin
      // A byte arriving on the timeout cycle is decoded with the current state
      case (state)
        IDLE: begin
          if (rx_dout == PS2_PFX_EXT)      state_nxt = GOT_E0;
          else if (rx_dout == PS2_PFX_BRK) state_nxt = GOT_F0;
          else if (!ps2_is_discard(rx_dout)) emit = 1'b1;
        end
        GOT_E0: begin
          if (rx_dout == PS2_PFX_BRK)      state_nxt = GOT_E0F0;
          else if (rx_dout == PS2_PFX_EXT) state_nxt = GOT_E0;
          else begin
            emit      = 1'b1;
            evt.ext   = 1'b1;
            state_nxt = IDLE;
          end
        end
        GOT_F0: begin
          state_nxt = IDLE;
          emit      = ~is_pfx;
          evt.brk   = 1'b1;
        end
        GOT_E0F0: begin
          state_nxt = IDLE;
          emit      = ~is_pfx;
          evt.ext   = 1'b1;
          evt.brk   = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      rx_en_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      rx_en_q <= ~fifo_full_w;
      if (rx_done_tick || (state == IDLE) || tmo_hit) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;
  logic       last_make_vld;
  logic       evt_match, suppress;

  assign evt_match = last_make_vld && (last_make == {evt.ext, evt.code});
  assign suppress  = ~evt.brk & evt_match;
  assign fifo_wr   = emit & ~suppress;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_make     <= '0;
      last_make_vld <= 1'b0;
    end else if (emit) begin
      if (evt.brk) begin
        if (evt_match) last_make_vld <= 1'b0;
      end else if (!evt_match) begin
        last_make     <= {evt.ext, evt.code};
        last_make_vld <= 1'b1;
      end
    end
  end
`else
  assign fifo_wr = emit;
`endif

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KBD_EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .wr    (fifo_wr),
    .din   (evt),
    .rd    (rd_en),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full_w),
    .ovf   (ovf_tick)
  );

  assign rx_en     = rx_en_q;
  assign fifo_full = fifo_full_w;
  assign key_valid = ~fifo_empty;
  assign key_code  = head.code;
  assign key_break = head.brk;
  assign key_ext   = head.ext;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - self-checking bench for ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       rd_en = 1'b0;
  logic       rx_en, key_valid, key_break, key_ext, fifo_full, ovf_tick;
  logic [7:0] key_code;

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_dout      (rx_dout),
    .rx_en        (rx_en),
    .rd_en        (rd_en),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_break    (key_break),
    .key_ext      (key_ext),
    .fifo_full    (fifo_full),
    .ovf_tick     (ovf_tick)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending-prefix flags, idle cycles since last byte,
  // event queue as {ext, brk, code}, last head shown, filter memory.
  bit         pend, p_ext, p_brk;
  int         idle_n;
  logic [9:0] q[$];
  logic [9:0] last_head;
  bit         lm_v;
  logic [8:0] lm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_disc(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  endfunction

  task automatic model_reset();
    pend = 0; p_ext = 0; p_brk = 0; idle_n = 0;
    q.delete();
    last_head = '0;
    lm_v = 0; lm = '0;
  endtask

  task automatic step(input bit tick, input logic [7:0] b, input bit rd);
    bit         emit, full_b, rd_eff, ovf_e;
    logic [9:0] e, head;
    emit = 0; e = '0; ovf_e = 0;
    full_b = (q.size() == DEPTH);
    rd_eff = rd && (q.size() > 0);
    rx_done_tick = tick;
    rx_dout = tick ? b : 8'($urandom);
    rd_en = rd;
    if (tick) begin
      idle_n = 0;
      if (!pend) begin
        if (b == 8'hE0) begin pend = 1; p_ext = 1; p_brk = 0; end
        else if (b == 8'hF0) begin pend = 1; p_ext = 0; p_brk = 1; end
        else if (!is_disc(b)) begin emit = 1; e = {2'b00, b}; end
      end else begin
        if (p_ext && !p_brk && b == 8'hF0) p_brk = 1;
        else if (p_ext && !p_brk && b == 8'hE0) p_ext = 1;
        else if (b == 8'hE0 || b == 8'hF0) pend = 0;
        else begin emit = 1; e = {p_ext, p_brk, b}; pend = 0; end
      end
    end else if (pend) begin
      idle_n++;
      if (idle_n == TMO) begin pend = 0; idle_n = 0; end
    end
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    if (emit) begin
      if (!e[8]) begin
        if (lm_v && lm == {e[9], e[7:0]}) emit = 0;
        else begin lm = {e[9], e[7:0]}; lm_v = 1; end
      end else if (lm_v && lm == {e[9], e[7:0]}) begin
        lm_v = 0;
      end
    end
`endif
    if (rd_eff) void'(q.pop_front());
    if (emit) begin
      if (!full_b || rd_eff) q.push_back(e);
      else ovf_e = 1;
    end
    @(posedge clk);
    #1;
    rx_done_tick = 0;
    rd_en = 0;
    head = (q.size() > 0) ? q[0] : last_head;
    chk("key_valid", 32'(key_valid), 32'(q.size() > 0));
    chk("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    chk("ovf_tick",  32'(ovf_tick),  32'(ovf_e));
    chk("rx_en",     32'(rx_en),     32'(!full_b));
    chk("key_code",  32'(key_code),  32'(head[7:0]));
    chk("key_break", 32'(key_break), 32'(head[8]));
    chk("key_ext",   32'(key_ext),   32'(head[9]));
    last_head = head;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_en"},     32'(rx_en),     32'(0));
    chk({tag, "_key_valid"}, 32'(key_valid), 32'(0));
    chk({tag, "_key_code"},  32'(key_code),  32'(0));
    chk({tag, "_key_break"}, 32'(key_break), 32'(0));
    chk({tag, "_key_ext"},   32'(key_ext),   32'(0));
    chk({tag, "_fifo_full"}, 32'(fifo_full), 32'(0));
    chk({tag, "_ovf_tick"},  32'(ovf_tick),  32'(0));
  endtask

  task automatic chk_head(input string tag, input logic [7:0] code, input bit brk, input bit ext);
    chk({tag, "_valid"}, 32'(key_valid), 32'(1));
    chk({tag, "_code"},  32'(key_code),  32'(code));
    chk({tag, "_break"}, 32'(key_break), 32'(brk));
    chk({tag, "_ext"},   32'(key_ext),   32'(ext));
  endtask

  initial begin
    logic [7:0] fill [5];
    logic [7:0] filt [6];
    int         n_evt;
    fill = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
    filt = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    #2 reset = 0;

    // First edge after release enables the receiver
    step(0, 8'h00, 0);
    chk("rx_en_after_release", 32'(rx_en), 32'(1));

    // Single make code, then pop
    step(1, 8'h1C, 0);
    chk_head("make1c", 8'h1C, 0, 0);
    step(0, 8'h00, 1);
    chk("make1c_popped", 32'(key_valid), 32'(0));

    // Extended break: E0 F0 75 gives exactly one event
    step(1, 8'hE0, 0);
    chk("e0_no_evt", 32'(key_valid), 32'(0));
    step(1, 8'hF0, 0);
    chk("f0_no_evt", 32'(key_valid), 32'(0));
    step(1, 8'h75, 0);
    chk_head("extbrk", 8'h75, 1, 1);
    step(0, 8'h00, 1);
    chk("extbrk_single", 32'(key_valid), 32'(0));

    // Timeout: F0, TMO idle cycles, 1C -> plain make
    step(1, 8'hF0, 0);
    for (int i = 0; i < TMO; i++) step(0, 8'h00, 0);
    step(1, 8'h1C, 0);
    chk_head("tmo_make", 8'h1C, 0, 0);
    step(0, 8'h00, 1);

    // One cycle short of timeout: byte still completes the break
    step(1, 8'hF0, 0);
    for (int i = 0; i < TMO - 1; i++) step(0, 8'h00, 0);
    step(1, 8'h1C, 0);
    chk_head("tmo_edge_brk", 8'h1C, 1, 0);
    step(0, 8'h00, 1);

    // Overflow: DEPTH+1 makes with no reads
    for (int i = 0; i < 5; i++) begin
      step(1, fill[i], 0);
      if (i == 3) chk("full_after_4", 32'(fifo_full), 32'(1));
      if (i == 4) begin
        chk("ovf_on_5th", 32'(ovf_tick), 32'(1));
        chk("rx_en_off", 32'(rx_en), 32'(0));
      end
    end
    step(0, 8'h00, 0);
    chk("ovf_one_cycle", 32'(ovf_tick), 32'(0));
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(key_code), 32'(fill[i]));
      step(0, 8'h00, 1);
    end
    chk("drained", 32'(key_valid), 32'(0));

    // Full FIFO, read and write on the same cycle
    for (int i = 0; i < 4; i++) step(1, fill[i], 0);
    step(1, 8'h2C, 1);
    chk("rdwr_full_stays", 32'(fifo_full), 32'(1));
    chk("rdwr_no_ovf", 32'(ovf_tick), 32'(0));
    for (int i = 1; i < 5; i++) begin
      chk("rdwr_order", 32'(key_code), 32'(fill[i]));
      step(0, 8'h00, 1);
    end

    // Typematic sequence, popping each event as it appears
    n_evt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, filt[i], 0);
      if (key_valid) begin
        n_evt++;
        step(0, 8'h00, 1);
      end
    end
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    chk("typematic_events", 32'(n_evt), 32'(3));
`else
    chk("typematic_events", 32'(n_evt), 32'(5));
`endif

    // Reset mid-sequence: queued events plus a pending E0
    step(1, 8'h15, 0);
    step(1, 8'h1D, 0);
    step(1, 8'hE0, 0);
    #2 reset = 1;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #2 reset = 0;
    model_reset();
    step(0, 8'h00, 0);
    step(1, 8'h75, 0);
    chk_head("post_rst_plain", 8'h75, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [7:0] b;
      int         r;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hAA;
        3: b = 8'hFA;
        default: b = 8'($urandom_range(1, 8'h7F));
      endcase
      step(($urandom_range(0, 99) < 55), b, ($urandom_range(0, 99) < 30));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
